cpu_boot_ctrl: RTL and testbench

- Sequencer that owns the external memory ports and the `enable` of the pipelined cpu.
- After `start`, it streams a program into instruction memory and an initial image into data memory, then runs the cpu for a programmed number of cycles.
- Finally it dumps a data-memory window out on a valid/ready stream.
- Sits between the testbench/host link and the cpu top; the host only sees two streams plus status.

---
 rtl/cpu_boot_ctrl_pkg.sv | 24 ++
 rtl/cpu_boot_ctrl_word_counter.sv | 28 ++
 rtl/cpu_boot_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared types and constants for the cpu boot controller: the sequencer state
// encoding, word size and default memory depths.
package cpu_boot_ctrl_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int IMEM_WORDS_DEF = 128;
    localparam int DMEM_WORDS_DEF = 256;
    localparam int RUN_W_DEF      = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        RUN,
        DUMP_RD,
        DUMP_WT,
        DONE
    } boot_state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/cpu_boot_ctrl_word_counter.sv
// Loadable down-counter with a zero flag; the sequencer loads it with
// (count - 1) so that zero marks the final word or cycle of a phase.
module boot_word_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer: loads imem/dmem from a stream, runs the cpu, dumps a dmem window.
// Optional load checksum is enabled with the macro CPU_BOOT_CTRL_CHECKSUM_EN.
module cpu_boot_ctrl
    import cpu_boot_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int DMEM_WORDS = DMEM_WORDS_DEF,
    parameter int RUN_W      = RUN_W_DEF
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(IMEM_WORDS):0]   n_imem,
    input  logic [$clog2(DMEM_WORDS):0]   n_dmem,
    input  logic [RUN_W-1:0]              run_cycles,
    input  logic [$clog2(DMEM_WORDS)-1:0] dump_base,
    input  logic [$clog2(DMEM_WORDS):0]   n_dump,
    input  logic                          s_valid,
    input  logic [31:0]                   s_data,
    output logic                          s_ready,
    output logic                          m_valid,
    output logic [31:0]                   m_data,
    input  logic                          m_ready,
    output logic [31:0]                   addr_ext,
    output logic                          wen_ext,
    output logic                          ren_ext,
    output logic [31:0]                   wdata_ext,
    output logic [31:0]                   addr_ext_2,
    output logic                          wen_ext_2,
    output logic                          ren_ext_2,
    output logic [31:0]                   wdata_ext_2,
    input  logic [31:0]                   rdata_ext_2,
    output logic                          cpu_enable,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   load_csum
);

    localparam int NI_W = $clog2(IMEM_WORDS) + 1;
    localparam int ND_W = $clog2(DMEM_WORDS) + 1;
    localparam int DW   = $clog2(DMEM_WORDS);
    localparam int LC_W = (NI_W > ND_W) ? NI_W : ND_W;

    boot_state_t state, nxt, after_st, after_li, after_ld;

    logic [NI_W-1:0]  cfg_ni, ni_clamp, sel_ni;
    logic [ND_W-1:0]  cfg_nd, nd_clamp, sel_nd;
    logic [ND_W-1:0]  cfg_nk, nk_clamp, sel_nk;
    logic [RUN_W-1:0] cfg_run, sel_run;
    logic [DW-1:0]    cfg_base, sel_base;

    logic [LC_W-1:0]  load_idx, load_val;
    logic [DW-1:0]    dump_idx, dump_idx_next;
    logic [31:0]      m_data_q;
    logic             capture;
    logic             start_take, acc_i, acc_d, hs;
    logic             load_ld, run_ld, dump_ld;
    logic             load_zero, run_zero, dump_zero;

    assign ni_clamp = (n_imem > NI_W'(IMEM_WORDS)) ? NI_W'(IMEM_WORDS) : n_imem;
    assign nd_clamp = (n_dmem > ND_W'(DMEM_WORDS)) ? ND_W'(DMEM_WORDS) : n_dmem;
    assign nk_clamp = (n_dump > ND_W'(DMEM_WORDS)) ? ND_W'(DMEM_WORDS) : n_dump;

    // A fresh session takes its configuration straight from the ports so that
    // zero-length phases can be skipped on the very start cycle.
    assign start_take = start && !abort && (state == IDLE || state == DONE);
    assign sel_ni     = start_take ? ni_clamp   : cfg_ni;
    assign sel_nd     = start_take ? nd_clamp   : cfg_nd;
    assign sel_nk     = start_take ? nk_clamp   : cfg_nk;
    assign sel_run    = start_take ? run_cycles : cfg_run;
    assign sel_base   = start_take ? dump_base  : cfg_base;

    assign after_ld = (sel_run != '0) ? RUN : ((sel_nk != '0) ? DUMP_RD : DONE);
    assign after_li = (sel_nd != '0) ? LOAD_D : after_ld;
    assign after_st = (sel_ni != '0) ? LOAD_I : after_li;

    assign acc_i = (state == LOAD_I) && s_valid;
    assign acc_d = (state == LOAD_D) && s_valid;
    assign hs    = (state == DUMP_WT) && m_ready;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: if (start) nxt = after_st;
            LOAD_I:     if (acc_i && load_zero) nxt = after_li;
            LOAD_D:     if (acc_d && load_zero) nxt = after_ld;
            RUN:        if (run_zero) nxt = (sel_nk != '0) ? DUMP_RD : DONE;
            DUMP_RD:    nxt = DUMP_WT;
            DUMP_WT:    if (hs) nxt = dump_zero ? DONE : DUMP_RD;
            default:    nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    assign load_ld  = (nxt == LOAD_I && state != LOAD_I) || (nxt == LOAD_D && state != LOAD_D);
    assign load_val = (nxt == LOAD_I) ? (LC_W'(sel_ni) - LC_W'(1)) : (LC_W'(sel_nd) - LC_W'(1));
    assign run_ld   = (nxt == RUN) && (state != RUN);
    assign dump_ld  = (nxt == DUMP_RD) && (state != DUMP_WT);

    boot_word_counter #(.W(LC_W)) u_load_cnt (
        .clk(clk), .arst_n(arst_n), .load(load_ld), .load_val(load_val),
        .dec(acc_i || acc_d), .zero(load_zero)
    );

    boot_word_counter #(.W(RUN_W)) u_run_cnt (
        .clk(clk), .arst_n(arst_n), .load(run_ld), .load_val(sel_run - RUN_W'(1)),
        .dec(state == RUN), .zero(run_zero)
    );

    boot_word_counter #(.W(ND_W)) u_dump_cnt (
        .clk(clk), .arst_n(arst_n), .load(dump_ld), .load_val(sel_nk - ND_W'(1)),
        .dec(hs), .zero(dump_zero)
    );

    assign dump_idx_next = (dump_idx == DW'(DMEM_WORDS - 1)) ? '0 : dump_idx + DW'(1);

    // The first DUMP_WT cycle forwards the memory read data; later stall
    // cycles replay the captured copy so m_data stays put under backpressure.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            cfg_ni   <= '0;
            cfg_nd   <= '0;
            cfg_nk   <= '0;
            cfg_run  <= '0;
            cfg_base <= '0;
            load_idx <= '0;
            dump_idx <= '0;
            capture  <= 1'b0;
            m_data_q <= '0;
        end else begin
            state <= nxt;
            if (start_take) begin
                cfg_ni   <= ni_clamp;
                cfg_nd   <= nd_clamp;
                cfg_nk   <= nk_clamp;
                cfg_run  <= run_cycles;
                cfg_base <= dump_base;
            end
            if (load_ld) begin
                load_idx <= '0;
            end else if (acc_i || acc_d) begin
                load_idx <= load_idx + LC_W'(1);
            end
            if (dump_ld) begin
                dump_idx <= sel_base;
            end else if (hs) begin
                dump_idx <= dump_idx_next;
            end
            capture <= (state == DUMP_RD) && (nxt == DUMP_WT);
            if (capture) m_data_q <= rdata_ext_2;
        end
    end

    assign s_ready     = (state == LOAD_I) || (state == LOAD_D);
    assign wen_ext     = acc_i;
    assign ren_ext     = 1'b0;
    assign addr_ext    = acc_i ? word_addr(32'(load_idx)) : '0;
    assign wdata_ext   = acc_i ? s_data : '0;
    assign wen_ext_2   = acc_d;
    assign ren_ext_2   = (state == DUMP_RD);
    assign wdata_ext_2 = acc_d ? s_data : '0;
    assign addr_ext_2  = acc_d ? word_addr(32'(load_idx)) :
                         (state == DUMP_RD) ? word_addr(32'(dump_idx)) : '0;
    assign m_valid     = (state == DUMP_WT);
    assign m_data      = capture ? rdata_ext_2 : m_data_q;
    assign cpu_enable  = (state == RUN);
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            csum <= '0;
        end else if (start_take) begin
            csum <= '0;
        end else if (acc_i || acc_d) begin
            csum <= csum + s_data;
        end
    end

    assign load_csum = csum;
`else
    assign load_csum = '0;
`endif

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl: a cycle table for load sessions plus
// hand sequences for run length, dump with backpressure, abort and reset.
module tb_cpu_boot_ctrl;

    logic        clk;
    logic        arst_n;
    logic        start, abort;
    logic [7:0]  n_imem;
    logic [8:0]  n_dmem;
    logic [15:0] run_cycles;
    logic [7:0]  dump_base;
    logic [8:0]  n_dump;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        cpu_enable, busy, done;
    logic [31:0] load_csum;

    int checks = 0;
    int fails  = 0;

    cpu_boot_ctrl dut (
        .clk(clk), .arst_n(arst_n), .start(start), .abort(abort),
        .n_imem(n_imem), .n_dmem(n_dmem), .run_cycles(run_cycles),
        .dump_base(dump_base), .n_dump(n_dump),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .load_csum(load_csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: 1-cycle read latency; word i reads D000_0000+i except
    // word 0, which returns what was last written; non-read cycles scramble.
    logic [31:0] dmem0;
    always @(posedge clk) begin
        if (wen_ext_2 && addr_ext_2 == 32'd0) dmem0 <= wdata_ext_2;
        if (ren_ext_2)
            rdata_ext_2 <= (addr_ext_2 == 32'd0) ? dmem0 : (32'hD000_0000 | (addr_ext_2 >> 2));
        else
            rdata_ext_2 <= 32'hBAD0_0000;
    end

    typedef struct {
        logic        st;
        logic        sv;
        logic [31:0] sd;
        logic [7:0]  ni;
        logic [8:0]  nd;
        logic [15:0] run;
        logic        ewen;
        logic        ewen2;
        logic [31:0] eaddr;
        logic        erdy;
        logic        ecpu;
        logic        ebusy;
        logic        edone;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mkv(input logic st, input logic sv, input logic [31:0] sd,
                                 input logic [7:0] ni, input logic [8:0] nd, input logic [15:0] run,
                                 input logic ewen, input logic ewen2, input logic [31:0] eaddr,
                                 input logic erdy, input logic ecpu, input logic ebusy,
                                 input logic edone);
        vec_t v;
        v.st = st; v.sv = sv; v.sd = sd; v.ni = ni; v.nd = nd; v.run = run;
        v.ewen = ewen; v.ewen2 = ewen2; v.eaddr = eaddr;
        v.erdy = erdy; v.ecpu = ecpu; v.ebusy = ebusy; v.edone = edone;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start      = v.st;
        s_valid    = v.sv;
        s_data     = v.sd;
        n_imem     = v.ni;
        n_dmem     = v.nd;
        run_cycles = v.run;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " s_ready"},    32'(s_ready),    32'd0);
        checkOutput({tag, " wen_ext"},    32'(wen_ext),    32'd0);
        checkOutput({tag, " wen_ext_2"},  32'(wen_ext_2),  32'd0);
        checkOutput({tag, " ren_ext"},    32'(ren_ext),    32'd0);
        checkOutput({tag, " ren_ext_2"},  32'(ren_ext_2),  32'd0);
        checkOutput({tag, " addr_ext"},   addr_ext,        32'd0);
        checkOutput({tag, " addr_ext_2"}, addr_ext_2,      32'd0);
        checkOutput({tag, " wdata_ext"},  wdata_ext,       32'd0);
        checkOutput({tag, " cpu_enable"}, 32'(cpu_enable), 32'd0);
        checkOutput({tag, " m_valid"},    32'(m_valid),    32'd0);
        checkOutput({tag, " m_data"},     m_data,          32'd0);
        checkOutput({tag, " busy"},       32'(busy),       32'd0);
        checkOutput({tag, " done"},       32'(done),       32'd0);
        checkOutput({tag, " load_csum"},  load_csum,       32'd0);
    endtask

    initial begin
        int cpu_hi;
        int wen_cnt;
        logic strobe_seen;

        vecs[0]  = mkv(1, 0, 32'h00, 4, 2, 3, 0, 0, 0,  0, 0, 0, 0);
        vecs[1]  = mkv(0, 1, 32'h11, 4, 2, 3, 1, 0, 0,  1, 0, 1, 0);
        vecs[2]  = mkv(0, 1, 32'h12, 4, 2, 3, 1, 0, 4,  1, 0, 1, 0);
        vecs[3]  = mkv(0, 1, 32'h13, 4, 2, 3, 1, 0, 8,  1, 0, 1, 0);
        vecs[4]  = mkv(0, 1, 32'h14, 4, 2, 3, 1, 0, 12, 1, 0, 1, 0);
        vecs[5]  = mkv(0, 1, 32'h15, 4, 2, 3, 0, 1, 0,  1, 0, 1, 0);
        vecs[6]  = mkv(0, 1, 32'h16, 4, 2, 3, 0, 1, 4,  1, 0, 1, 0);
        vecs[7]  = mkv(0, 0, 32'h00, 4, 2, 3, 0, 0, 0,  0, 1, 1, 0);
        vecs[8]  = mkv(0, 0, 32'h00, 4, 2, 3, 0, 0, 0,  0, 1, 1, 0);
        vecs[9]  = mkv(0, 0, 32'h00, 4, 2, 3, 0, 0, 0,  0, 1, 1, 0);
        vecs[10] = mkv(0, 1, 32'h99, 4, 2, 3, 0, 0, 0,  0, 0, 0, 1);
        vecs[11] = mkv(1, 0, 32'h00, 3, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        vecs[12] = mkv(0, 0, 32'h00, 3, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[13] = mkv(0, 1, 32'hA0, 3, 0, 0, 1, 0, 0,  1, 0, 1, 0);
        vecs[14] = mkv(0, 0, 32'h00, 3, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[15] = mkv(0, 1, 32'hA1, 3, 0, 0, 1, 0, 4,  1, 0, 1, 0);
        vecs[16] = mkv(0, 0, 32'h00, 3, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[17] = mkv(0, 1, 32'hA2, 3, 0, 0, 1, 0, 8,  1, 0, 1, 0);
        vecs[18] = mkv(0, 0, 32'h00, 3, 0, 0, 0, 0, 0,  0, 0, 0, 1);

        arst_n = 1'b0; start = 0; abort = 0; n_imem = 0; n_dmem = 0; run_cycles = 0;
        dump_base = 0; n_dump = 0; s_valid = 0; s_data = 0; m_ready = 0;
        @(negedge clk); @(negedge clk);
        #1 checkAllZero("reset");
        @(negedge clk); arst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d wen_ext", i),   32'(wen_ext),   32'(vecs[i].ewen));
            checkOutput($sformatf("vec%0d wen_ext_2", i), 32'(wen_ext_2), 32'(vecs[i].ewen2));
            checkOutput($sformatf("vec%0d addr_ext", i),   addr_ext,   vecs[i].ewen  ? vecs[i].eaddr : 32'd0);
            checkOutput($sformatf("vec%0d addr_ext_2", i), addr_ext_2, vecs[i].ewen2 ? vecs[i].eaddr : 32'd0);
            checkOutput($sformatf("vec%0d wdata_ext", i),   wdata_ext,   vecs[i].ewen  ? vecs[i].sd : 32'd0);
            checkOutput($sformatf("vec%0d wdata_ext_2", i), wdata_ext_2, vecs[i].ewen2 ? vecs[i].sd : 32'd0);
            checkOutput($sformatf("vec%0d s_ready", i),    32'(s_ready),    32'(vecs[i].erdy));
            checkOutput($sformatf("vec%0d cpu_enable", i), 32'(cpu_enable), 32'(vecs[i].ecpu));
            checkOutput($sformatf("vec%0d busy", i),       32'(busy),       32'(vecs[i].ebusy));
            checkOutput($sformatf("vec%0d done", i),       32'(done),       32'(vecs[i].edone));
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
            if (i == 10) checkOutput("csum session A", load_csum, 32'h11 + 32'h12 + 32'h13 + 32'h14 + 32'h15 + 32'h16);
`endif
        end
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
        checkOutput("csum session B", load_csum, 32'hA0 + 32'hA1 + 32'hA2);
`else
        checkOutput("csum tied off", load_csum, 32'd0);
`endif

        // Run length: exactly 10 enable cycles, a start mid-run must be ignored.
        @(negedge clk);
        start = 1; n_imem = 0; n_dmem = 0; run_cycles = 16'd10; n_dump = 0; s_valid = 1; s_data = 32'h55;
        cpu_hi = 0; strobe_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start  = (i == 3);
            n_imem = (i == 3) ? 8'd5 : 8'd0;
            #1;
            if (cpu_enable) begin
                cpu_hi++;
                if (wen_ext || wen_ext_2 || ren_ext || ren_ext_2 || s_ready) strobe_seen = 1'b1;
            end
        end
        s_valid = 0;
        checkOutput("run cpu_enable cycles", 32'(cpu_hi), 32'd10);
        checkOutput("run strobes during run", 32'(strobe_seen), 32'd0);
        checkOutput("run done after run", 32'(done), 32'd1);

        // Abort in RUN drops cpu_enable next cycle and returns to IDLE.
        @(negedge clk); start = 1; run_cycles = 16'd100;
        @(negedge clk); start = 0; #1;
        checkOutput("abort pre cpu_enable", 32'(cpu_enable), 32'd1);
        @(negedge clk); @(negedge clk); abort = 1;
        @(negedge clk); abort = 0; #1;
        checkOutput("abort cpu_enable", 32'(cpu_enable), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);

        // Start and abort together: abort wins, stay IDLE.
        @(negedge clk); start = 1; abort = 1; n_imem = 8'd4; run_cycles = 0;
        @(negedge clk); start = 0; abort = 0; n_imem = 0; #1;
        checkOutput("start+abort busy", 32'(busy), 32'd0);
        checkOutput("start+abort done", 32'(done), 32'd0);
        checkOutput("start+abort s_ready", 32'(s_ready), 32'd0);

        // All counts zero: DONE one cycle after start.
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; #1;
        checkOutput("zero counts done", 32'(done), 32'd1);
        checkOutput("zero counts busy", 32'(busy), 32'd0);

        // Dump with wrap-around and a 5-cycle stall on the first word.
        @(negedge clk);
        start = 1; n_imem = 0; n_dmem = 9'd1; run_cycles = 0; dump_base = 8'd254; n_dump = 9'd3;
        @(negedge clk); start = 0; s_valid = 1; s_data = 32'hCAFE_0001; #1;
        checkOutput("dump preload wen_ext_2", 32'(wen_ext_2), 32'd1);
        checkOutput("dump preload addr_ext_2", addr_ext_2, 32'd0);
        checkOutput("dump preload wdata_ext_2", wdata_ext_2, 32'hCAFE_0001);
        @(negedge clk); s_valid = 0; #1;
        checkOutput("dump rd0 ren", 32'(ren_ext_2), 32'd1);
        checkOutput("dump rd0 addr", addr_ext_2, 32'd1016);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); m_ready = (i == 5); #1;
            checkOutput($sformatf("dump w0 m_valid c%0d", i), 32'(m_valid), 32'd1);
            checkOutput($sformatf("dump w0 m_data c%0d", i), m_data, 32'hD000_00FE);
        end
        @(negedge clk); #1;
        checkOutput("dump rd1 ren", 32'(ren_ext_2), 32'd1);
        checkOutput("dump rd1 addr", addr_ext_2, 32'd1020);
        checkOutput("dump rd1 m_valid", 32'(m_valid), 32'd0);
        @(negedge clk); #1;
        checkOutput("dump w1 m_valid", 32'(m_valid), 32'd1);
        checkOutput("dump w1 m_data", m_data, 32'hD000_00FF);
        @(negedge clk); #1;
        checkOutput("dump rd2 ren", 32'(ren_ext_2), 32'd1);
        checkOutput("dump rd2 addr", addr_ext_2, 32'd0);
        @(negedge clk); #1;
        checkOutput("dump w2 m_valid", 32'(m_valid), 32'd1);
        checkOutput("dump w2 m_data", m_data, 32'hCAFE_0001);
        @(negedge clk); m_ready = 0; #1;
        checkOutput("dump done", 32'(done), 32'd1);
        checkOutput("dump m_valid after", 32'(m_valid), 32'd0);

        // Asynchronous reset in the middle of LOAD_I after three words.
        @(negedge clk);
        start = 1; n_imem = 8'd8; n_dmem = 0; run_cycles = 0; n_dump = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); start = 0; s_valid = 1; s_data = 32'h30 + 32'(i); #1;
            checkOutput($sformatf("rst load w%0d wen", i), 32'(wen_ext), 32'd1);
            checkOutput($sformatf("rst load w%0d addr", i), addr_ext, 32'(4 * i));
        end
        @(negedge clk); s_data = 32'h33; #2; arst_n = 1'b0; #1;
        checkAllZero("mid reset");
        @(negedge clk); @(negedge clk); arst_n = 1'b1;
        wen_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (wen_ext || wen_ext_2) wen_cnt++;
        end
        checkOutput("post reset writes", 32'(wen_cnt), 32'd0);
        checkOutput("post reset busy", 32'(busy), 32'd0);
        checkOutput("post reset done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
